// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed common-anode 7-segment driver.
// A prescaler paces the digit scan. New data lands in a shadow buffer and is
// promoted to the displayed (active) buffer only at a frame boundary, so a
// frame never mixes old and new digits.
module seven_seg_scanner #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter bit HEX_MODE    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  lz_blank,
    input  logic                  en,
    output logic [6:0]            seg,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [4*DIGITS-1:0] active_reg, shadow_reg;
    logic [DIGITS-1:0]   active_dp_reg, shadow_dp_reg;
    logic                pending_reg;
    logic [6:0]          seg_reg, seg_next;
    logic                dp_out_reg, dp_out_next;
    logic [DIGITS-1:0]   an_reg, an_next;
    logic                frame_done_reg;

    logic                tick;
    logic                last_digit;
    logic                wrap;
    logic [3:0]          nib [DIGITS];
    logic [DIGITS-1:0]   lead_zero;
    logic [3:0]          cur_nib;
    logic                blank;

    assign tick       = (cnt_reg == CNT_W'(REFRESH_DIV - 1));
    assign last_digit = (idx_reg == IDX_W'(DIGITS - 1));
    assign wrap       = tick && last_digit;

    // Split the active buffer into nibbles; lead_zero[i] means every digit
    // from i up to the most significant one is zero.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib[gi]       = active_reg[4*gi +: 4];
            assign lead_zero[gi] = (active_reg[4*DIGITS-1:4*gi] == '0);
        end
    endgenerate

    assign cur_nib = nib[idx_reg];
    assign blank   = lz_blank && (idx_reg != '0) && lead_zero[idx_reg];

    // Nibble to abcdefg glyph; A-F become a dash unless hex glyphs are enabled.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        g = 7'b0000001;
        case (n)
            4'h0: g = 7'b1111110;
            4'h1: g = 7'b0110000;
            4'h2: g = 7'b1101101;
            4'h3: g = 7'b1111001;
            4'h4: g = 7'b0110011;
            4'h5: g = 7'b1011011;
            4'h6: g = 7'b1011111;
            4'h7: g = 7'b1110000;
            4'h8: g = 7'b1111111;
            4'h9: g = 7'b1110011;
            4'hA: g = HEX_MODE ? 7'b1110111 : 7'b0000001;
            4'hB: g = HEX_MODE ? 7'b0011111 : 7'b0000001;
            4'hC: g = HEX_MODE ? 7'b1001110 : 7'b0000001;
            4'hD: g = HEX_MODE ? 7'b0111101 : 7'b0000001;
            4'hE: g = HEX_MODE ? 7'b1001111 : 7'b0000001;
            4'hF: g = HEX_MODE ? 7'b1000111 : 7'b0000001;
            default: g = 7'b0000001;
        endcase
        return g;
    endfunction

    // Prescaler and digit index sequencing.
    always_comb begin
        cnt_next = tick ? '0 : cnt_reg + CNT_W'(1);
        idx_next = idx_reg;
        if (tick) begin
            idx_next = last_digit ? '0 : idx_reg + IDX_W'(1);
        end
    end

    // Output decode for the digit currently selected; registered below.
    always_comb begin
        seg_next    = blank ? 7'b0000000 : glyph(cur_nib);
        dp_out_next = active_dp_reg[idx_reg];
        an_next     = en ? ~(DIGITS'(1) << idx_reg) : '1;
    end

    // Scan counters, double buffer and registered pin outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg        <= '0;
            idx_reg        <= '0;
            active_reg     <= '0;
            active_dp_reg  <= '0;
            shadow_reg     <= '0;
            shadow_dp_reg  <= '0;
            pending_reg    <= 1'b0;
            seg_reg        <= 7'b0000000;
            dp_out_reg     <= 1'b0;
            an_reg         <= '1;
            frame_done_reg <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            seg_reg        <= seg_next;
            dp_out_reg     <= dp_out_next;
            an_reg         <= an_next;
            frame_done_reg <= wrap;

            if (load) begin
                shadow_reg    <= value;
                shadow_dp_reg <= dp;
            end

            // At the frame boundary a same-cycle load bypasses the shadow,
            // otherwise any pending shadow contents are promoted.
            if (wrap) begin
                if (load) begin
                    active_reg    <= value;
                    active_dp_reg <= dp;
                end else if (pending_reg) begin
                    active_reg    <= shadow_reg;
                    active_dp_reg <= shadow_dp_reg;
                end
                pending_reg <= 1'b0;
            end else if (load) begin
                pending_reg <= 1'b1;
            end
        end
    end

    assign seg        = seg_reg;
    assign dp_out     = dp_out_reg;
    assign an         = an_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: two instances (BCD and hex glyphs) share one
// stimulus stream; an arithmetic model predicts every output cycle, and a few
// hand-computed literals pin the model at known scan positions.
module tb_seven_seg_scanner;

    localparam int D     = 4;
    localparam int R     = 4;
    localparam int FRAME = D * R;

    logic        clk = 1'b0;
    logic        rst, load, lz_blank, en;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [6:0]  seg0, seg1;
    logic        dpo0, dpo1, fd0, fd1;
    logic [3:0]  an0, an1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seven_seg_scanner #(.DIGITS(D), .REFRESH_DIV(R), .HEX_MODE(1'b0)) dut_bcd (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp(dp_in),
        .lz_blank(lz_blank), .en(en), .seg(seg0), .dp_out(dpo0), .an(an0),
        .frame_done(fd0)
    );

    seven_seg_scanner #(.DIGITS(D), .REFRESH_DIV(R), .HEX_MODE(1'b1)) dut_hex (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp(dp_in),
        .lz_blank(lz_blank), .en(en), .seg(seg1), .dp_out(dpo1), .an(an1),
        .frame_done(fd1)
    );

    // ---------------- behavioural model ----------------
    int          m_pos = 0;        // clock edges since reset released
    logic [15:0] m_active, m_shadow;
    logic [3:0]  m_dp, m_shadow_dp;
    bit          m_pending;
    bit          m_valid = 1'b0;
    logic [6:0]  exp_seg_bcd, exp_seg_hex;
    logic        exp_dp, exp_fd;
    logic [3:0]  exp_an;

    function automatic logic [6:0] model_glyph(input int n, input bit hex);
        logic [6:0] tbl [16];
        tbl = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
                7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
        if (n > 9 && !hex) return 7'b0000001;
        return tbl[n];
    endfunction

    function automatic logic [6:0] model_seg(input logic [15:0] act, input int d,
                                             input bit lz, input bit hex);
        int digit_val;
        int upper;
        digit_val = (int'(act) / (1 << (4 * d))) % 16;
        upper     = int'(act) / (1 << (4 * d));
        if (lz && d > 0 && upper == 0) return 7'b0000000;
        return model_glyph(digit_val, hex);
    endfunction

    function automatic int model_idx(input int p);
        return (p / R) % D;
    endfunction

    // Model advances on every edge using only frame arithmetic.
    always @(posedge clk) begin
        m_valid <= 1'b1;
        if (rst) begin
            m_pos       <= 0;
            m_active    <= '0;
            m_dp        <= '0;
            m_shadow    <= '0;
            m_shadow_dp <= '0;
            m_pending   <= 1'b0;
            exp_seg_bcd <= 7'b0000000;
            exp_seg_hex <= 7'b0000000;
            exp_dp      <= 1'b0;
            exp_an      <= 4'b1111;
            exp_fd      <= 1'b0;
        end else begin
            exp_seg_bcd <= model_seg(m_active, model_idx(m_pos), lz_blank, 1'b0);
            exp_seg_hex <= model_seg(m_active, model_idx(m_pos), lz_blank, 1'b1);
            exp_dp      <= m_dp[model_idx(m_pos)];
            exp_an      <= en ? (4'b1111 ^ (4'b0001 << model_idx(m_pos))) : 4'b1111;
            exp_fd      <= (m_pos % FRAME == FRAME - 1);
            if (load) begin
                m_shadow    <= value;
                m_shadow_dp <= dp_in;
            end
            if (m_pos % FRAME == FRAME - 1) begin
                if (load) begin
                    m_active <= value;
                    m_dp     <= dp_in;
                end else if (m_pending) begin
                    m_active <= m_shadow;
                    m_dp     <= m_shadow_dp;
                end
                m_pending <= 1'b0;
            end else if (load) begin
                m_pending <= 1'b1;
            end
            m_pos <= m_pos + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at t=%0t pos=%0d: got %0b required %0b", name, $time, m_pos, act, req);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("seg_bcd", 32'(seg0), 32'(exp_seg_bcd));
            check("seg_hex", 32'(seg1), 32'(exp_seg_hex));
            check("dp_bcd",  32'(dpo0), 32'(exp_dp));
            check("dp_hex",  32'(dpo1), 32'(exp_dp));
            check("an_bcd",  32'(an0),  32'(exp_an));
            check("an_hex",  32'(an1),  32'(exp_an));
            check("fd_bcd",  32'(fd0),  32'(exp_fd));
            check("fd_hex",  32'(fd1),  32'(exp_fd));
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_pos(input int p);
        int n;
        n = 0;
        while (m_pos != p && n < 300) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (m_pos != p) begin
            n_fail++;
            $display("FAIL wait_pos: got pos %0d required %0d", m_pos, p);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        load  = 1'b1;
        value = v;
        dp_in = d;
        $display("load value=%h dp=%b at pos %0d", v, d, m_pos);
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; lz_blank = 1'b0; en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_an",  32'(an0),  32'b1111);
        check("rst_seg", 32'(seg0), 32'b0000000);
        check("rst_fd",  32'(fd0),  32'b0);
        rst = 1'b0;
        wait_pos(1);
        check("rel_an",  32'(an0),  32'b1110);
        check("rel_seg", 32'(seg0), 32'b1111110);

        // Scan of 1234 with a decimal point on digit 2
        wait_pos(5);
        do_load(16'h1234, 4'b0100);
        wait_pos(16);
        check("fd_frame1", 32'(fd0), 32'b1);
        wait_pos(17);
        check("scan_d0_seg", 32'(seg0), 32'b0110011);
        check("scan_d0_an",  32'(an0),  32'b1110);
        wait_pos(25);
        check("scan_d2_seg", 32'(seg0), 32'b1101101);
        check("scan_d2_an",  32'(an0),  32'b1011);
        check("scan_d2_dp",  32'(dpo0), 32'b1);
        wait_pos(29);
        check("scan_d3_seg", 32'(seg0), 32'b0110000);
        check("scan_d3_an",  32'(an0),  32'b0111);

        // Two loads in one frame: only the later one reaches the display
        wait_pos(35);
        do_load(16'h1111, 4'b0000);
        wait_pos(41);
        do_load(16'h2222, 4'b0000);
        wait_pos(49);
        check("lastwins_seg", 32'(seg0), 32'b1101101);

        // Load coinciding with the frame wrap, leading-zero blanking on
        wait_pos(63);
        lz_blank = 1'b1;
        do_load(16'h0009, 4'b0000);
        check("wrap_fd", 32'(fd0), 32'b1);
        wait_pos(65);
        check("wrap_d0_seg", 32'(seg0), 32'b1110011);
        wait_pos(69);
        check("lz_d1_seg", 32'(seg0), 32'b0000000);
        check("lz_d1_an",  32'(an0),  32'b1101);
        wait_pos(72);
        lz_blank = 1'b0;
        wait_pos(73);
        check("nolz_d2_seg", 32'(seg0), 32'b1111110);

        // Glyph sets
        wait_pos(74);
        do_load(16'hABCD, 4'b0000);
        wait_pos(81);
        check("bcd_D", 32'(seg0), 32'b0000001);
        check("hex_d", 32'(seg1), 32'b0111101);
        wait_pos(85);
        check("hex_C", 32'(seg1), 32'b1001110);
        wait_pos(89);
        check("hex_b", 32'(seg1), 32'b0011111);
        wait_pos(93);
        check("hex_A", 32'(seg1), 32'b1110111);
        check("bcd_A", 32'(seg0), 32'b0000001);

        // Display disable for 5 cycles, scan keeps running
        wait_pos(97);
        en = 1'b0;
        wait_pos(100);
        check("en0_an",     32'(an0),  32'b1111);
        check("en0_seg",    32'(seg0), 32'b0000001);
        check("en0_seghex", 32'(seg1), 32'b0111101);
        do_load(16'h5555, 4'b1111);
        wait_pos(102);
        en = 1'b1;
        wait_pos(103);
        check("en1_an", 32'(an0), 32'b1101);

        // Reset mid-frame drops the pending 5555
        rst = 1'b1;
        @(negedge clk);
        check("midrst_an",  32'(an0),  32'b1111);
        check("midrst_seg", 32'(seg0), 32'b0000000);
        rst = 1'b0;
        wait_pos(1);
        check("post_rst_seg", 32'(seg0), 32'b1111110);
        check("post_rst_an",  32'(an0),  32'b1110);
        wait_pos(21);
        check("lost_load_seg", 32'(seg0), 32'b1111110);
        wait_pos(34);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, pos %0d", m_pos);
        $fatal(1, "timeout");
    end

endmodule
